// File: rtl/ex_mem_ctl.sv
// EX/MEM pipeline register: stall hold, bubble insertion, flush and madd/msub feedback.
// Define EX_MEM_PERF_EN to add the perf_clr input and the saturating bubble_cnt output.
module ex_mem_ctl #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int OP_W    = 8,
   parameter int STALL_W = 6,
   parameter int EX_IDX  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [STALL_W-1:0]    stall,
   input  logic                  flush,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic [REG_AW-1:0]     ex_wd,
   input  logic                  ex_wreg,
   input  logic                  ex_whilo,
   input  logic [DATA_W-1:0]     ex_hi,
   input  logic [DATA_W-1:0]     ex_lo,
   input  logic [OP_W-1:0]       ex_aluop,
   input  logic [DATA_W-1:0]     ex_mem_addr,
   input  logic [DATA_W-1:0]     ex_reg2,
   input  logic [2*DATA_W-1:0]   ex_hilo_temp,
   input  logic [1:0]            ex_cnt,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [REG_AW-1:0]     mem_wd,
   output logic                  mem_wreg,
   output logic                  mem_whilo,
   output logic [DATA_W-1:0]     mem_hi,
   output logic [DATA_W-1:0]     mem_lo,
   output logic [OP_W-1:0]       mem_aluop,
   output logic [DATA_W-1:0]     mem_mem_addr,
   output logic [DATA_W-1:0]     mem_reg2,
   output logic                  mem_valid,
   output logic [2*DATA_W-1:0]   hilo_temp_o,
`ifdef EX_MEM_PERF_EN
   input  logic                  perf_clr,
   output logic [31:0]           bubble_cnt,
`endif
   output logic [1:0]            cnt_o
);

   typedef struct packed {
      logic [DATA_W-1:0] wdata;
      logic [REG_AW-1:0] wd;
      logic              wreg;
      logic              whilo;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic [OP_W-1:0]   aluop;
      logic [DATA_W-1:0] mem_addr;
      logic [DATA_W-1:0] reg2;
      logic              valid;
   } slot_t;

   slot_t               slot_q, slot_d;
   logic [2*DATA_W-1:0] hilo_temp_q, hilo_temp_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                ex_stall, mem_stall;
   logic                unused_stall;

   assign ex_stall     = stall[EX_IDX];
   assign mem_stall    = stall[EX_IDX+1];
   assign unused_stall = ^stall;

   // An all-zero slot is the bubble: wreg/whilo low, valid low.
   always_comb begin
      slot_d      = slot_q;
      hilo_temp_d = hilo_temp_q;
      cnt_d       = cnt_q;
      if (flush) begin
         slot_d      = '0;
         hilo_temp_d = '0;
         cnt_d       = '0;
      end else if (!mem_stall) begin
         if (ex_stall) begin
            slot_d      = '0;
            hilo_temp_d = ex_hilo_temp;
            cnt_d       = ex_cnt;
         end else begin
            slot_d.wdata    = ex_wdata;
            slot_d.wd       = ex_wd;
            slot_d.wreg     = ex_wreg;
            slot_d.whilo    = ex_whilo;
            slot_d.hi       = ex_hi;
            slot_d.lo       = ex_lo;
            slot_d.aluop    = ex_aluop;
            slot_d.mem_addr = ex_mem_addr;
            slot_d.reg2     = ex_reg2;
            slot_d.valid    = 1'b1;
            hilo_temp_d     = '0;
            cnt_d           = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q      <= '0;
         hilo_temp_q <= '0;
         cnt_q       <= '0;
      end else begin
         slot_q      <= slot_d;
         hilo_temp_q <= hilo_temp_d;
         cnt_q       <= cnt_d;
      end
   end

   assign mem_wdata    = slot_q.wdata;
   assign mem_wd       = slot_q.wd;
   assign mem_wreg     = slot_q.wreg;
   assign mem_whilo    = slot_q.whilo;
   assign mem_hi       = slot_q.hi;
   assign mem_lo       = slot_q.lo;
   assign mem_aluop    = slot_q.aluop;
   assign mem_mem_addr = slot_q.mem_addr;
   assign mem_reg2     = slot_q.reg2;
   assign mem_valid    = slot_q.valid;
   assign hilo_temp_o  = hilo_temp_q;
   assign cnt_o        = cnt_q;

`ifdef EX_MEM_PERF_EN
   logic        bubble_ins;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   assign bubble_ins = flush | (ex_stall & ~mem_stall);

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (perf_clr) begin
         bubble_cnt_d = '0;
      end else if (bubble_ins && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
